// File: rtl/counter_cmd_sched.sv
// counter_cmd_sched: two-requester round-robin command scheduler driving a loadable up-counter
module counter_cmd_sched #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [1:0]    req0_op,
  input  logic [DW-1:0] req0_arg,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [1:0]    req1_op,
  input  logic [DW-1:0] req1_arg,
  input  logic          abort,
  input  logic [DW-1:0] ctr_value,
  output logic          ctr_load,
  output logic          ctr_count_up,
  output logic [DW-1:0] ctr_data,
  output logic          busy,
  output logic          cmd_done,
  output logic          done_src
);
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_RUN  = 2'b11;
  typedef enum logic {IDLE, EXEC} state_t;
  state_t        state;
  logic [DW-1:0] remaining;
  logic          last_grant;
  logic          cur_src;
  logic          sel;
  logic          accept;
  logic [1:0]    sel_op;
  logic [DW-1:0] sel_arg;
  logic [DW-1:0] n;
  assign req0_ready = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
  // pick the granted request and work out how many increments it needs
  always_comb begin
    sel     = req1_ready;
    accept  = req0_ready || req1_ready;
    sel_op  = sel ? req1_op : req0_op;
    sel_arg = sel ? req1_arg : req0_arg;
    n       = (sel_op == OP_RUN) ? sel_arg - ctr_value : (sel_op == OP_STEP) ? sel_arg : '0;
  end
  // command FSM: turns the accepted command into registered strobes and a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      remaining    <= '0;
      last_grant   <= 1'b1;
      cur_src      <= 1'b0;
      ctr_load     <= 1'b0;
      ctr_count_up <= 1'b0;
      ctr_data     <= '0;
      busy         <= 1'b0;
      cmd_done     <= 1'b0;
      done_src     <= 1'b0;
    end else begin
      ctr_load     <= 1'b0;
      ctr_count_up <= 1'b0;
      cmd_done     <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          last_grant <= sel;
          cur_src    <= sel;
          if (sel_op == OP_LOAD) begin
            ctr_load <= 1'b1;
            ctr_data <= sel_arg;
            busy     <= 1'b1;
            state    <= EXEC;
          end else if (n != '0) begin
            ctr_count_up <= 1'b1;
            remaining    <= n - 1'b1;
            busy         <= 1'b1;
            state        <= EXEC;
          end else begin
            cmd_done <= 1'b1;
            done_src <= sel;
          end
        end
      end else if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        remaining <= '0;
      end else if (remaining != '0) begin
        ctr_count_up <= 1'b1;
        remaining    <= remaining - 1'b1;
      end else begin
        state    <= IDLE;
        busy     <= 1'b0;
        cmd_done <= 1'b1;
        done_src <= cur_src;
      end
    end
  end
endmodule

// File: tb/tb_counter_cmd_sched.sv
// tb_counter_cmd_sched: directed vectors, corner sequences and a random scoreboard run
module tb_counter_cmd_sched;
  localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, STEP = 2'b10, RUN = 2'b11;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, abort = 1'b0;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [7:0] req0_arg = '0, req1_arg = '0;
  logic req0_ready, req1_ready, ctr_load, ctr_count_up, busy, cmd_done, done_src;
  logic [7:0] ctr_data, ctr_v;
  logic preset_en = 1'b0;
  logic [7:0] preset_val = '0;
  int n_checks = 0, n_fail = 0;

  counter_cmd_sched #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_arg(req0_arg),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_arg(req1_arg),
    .abort(abort), .ctr_value(ctr_v), .ctr_load(ctr_load), .ctr_count_up(ctr_count_up),
    .ctr_data(ctr_data), .busy(busy), .cmd_done(cmd_done), .done_src(done_src)
  );

  always #5 clk = ~clk;

  // the counter being controlled, with a bench-side preset
  always @(posedge clk) begin
    if (preset_en) ctr_v <= preset_val;
    else if (ctr_load) ctr_v <= ctr_data;
    else if (ctr_count_up) ctr_v <= ctr_v + 8'd1;
  end

  typedef struct {
    bit         src;
    logic [1:0] op;
    logic [7:0] arg;
    logic [7:0] init;
    bit         exp_load;
    int         exp_cu;
    logic [7:0] exp_final;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input bit s, input bit v, input logic [1:0] op, input logic [7:0] arg);
    if (s) begin req1_valid = v; req1_op = op; req1_arg = arg; end
    else begin req0_valid = v; req0_op = op; req0_arg = arg; end
  endtask

  task automatic preset(input logic [7:0] val);
    @(negedge clk); preset_en = 1'b1; preset_val = val;
    @(negedge clk); preset_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int nl, nc, nb, lat, ds, exp_str;
    bit got;
    preset(v.init);
    set_req(v.src, 1'b1, v.op, v.arg);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (v.src ? req1_ready : req0_ready) begin got = 1; break; end
      @(negedge clk);
    end
    chk("vec_accept", int'(got), 1);
    if (got) @(posedge clk);
    @(negedge clk);
    set_req(v.src, 1'b0, v.op, v.arg);
    nl = 0; nc = 0; nb = 0; lat = 0; ds = -1;
    for (int t = 1; t <= 400; t++) begin
      nl += int'(ctr_load); nc += int'(ctr_count_up); nb += int'(busy);
      if (cmd_done) begin lat = t; ds = int'(done_src); break; end
      @(negedge clk);
    end
    exp_str = v.exp_load ? 1 : v.exp_cu;
    chk("vec_load_cycles", nl, int'(v.exp_load));
    chk("vec_count_cycles", nc, v.exp_cu);
    chk("vec_busy_cycles", nb, exp_str);
    chk("vec_done_latency", lat, exp_str + 1);
    chk("vec_done_src", ds, int'(v.src));
    chk("vec_final_value", int'(ctr_v), int'(v.exp_final));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, ncu, bad, cyc, free_at, done_at, win_lo, win_hi, k, s;
    bit is_load, lg, e0, e1, in_win, dsrc;
    bit pend[2];
    logic [1:0] pop[2];
    logic [7:0] parg[2], ectr, n8;
    vecs[0] = '{0, LOAD, 8'h48, 8'h00, 1, 0,   8'h48};
    vecs[1] = '{1, STEP, 8'd3,  8'h10, 0, 3,   8'h13};
    vecs[2] = '{1, STEP, 8'd0,  8'h13, 0, 0,   8'h13};
    vecs[3] = '{0, RUN,  8'd4,  8'd250,0, 10,  8'h04};
    vecs[4] = '{1, RUN,  8'h33, 8'h33, 0, 0,   8'h33};
    vecs[5] = '{0, NOP,  8'h99, 8'h20, 0, 0,   8'h20};
    vecs[6] = '{1, LOAD, 8'hFF, 8'h01, 1, 0,   8'hFF};
    vecs[7] = '{0, STEP, 8'd255,8'h00, 0, 255, 8'hFF};
    vecs[8] = '{1, RUN,  8'h00, 8'h01, 0, 255, 8'h00};
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_load", int'(ctr_load), 0);
    chk("rst_count_up", int'(ctr_count_up), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(cmd_done), 0);
    chk("rst_done_src", int'(done_src), 0);
    chk("rst_data", int'(ctr_data), 0);
    rst_n = 1'b1;
    foreach (vecs[i]) run_vec(vecs[i]);
    // both requesters hammer STEP 1: grants alternate, accepts land in done cycles
    @(negedge clk);
    set_req(0, 1'b1, STEP, 8'd1);
    set_req(1, 1'b1, STEP, 8'd1);
    acc = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      chk("rr_exclusive", int'(req0_ready && req1_ready), 0);
      if (req0_ready || req1_ready) begin
        chk("rr_grant_order", int'(req1_ready), acc % 2);
        if (acc > 0) chk("rr_b2b_in_done", int'(cmd_done), 1);
        acc++;
        if (acc == 8) break;
      end
      @(negedge clk);
    end
    chk("rr_accepts", acc, 8);
    @(posedge clk); #1;
    set_req(0, 1'b0, STEP, 8'd1);
    set_req(1, 1'b0, STEP, 8'd1);
    bad = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_done) begin bad = 0; chk("rr_last_src", int'(done_src), 1); break; end
    end
    chk("rr_last_done_timeout", bad, 0);
    // abort on the 5th increment of STEP 200
    preset(8'h00);
    set_req(0, 1'b1, STEP, 8'd200);
    #1 chk("ab_ready", int'(req0_ready), 1);
    @(posedge clk); @(negedge clk);
    set_req(0, 1'b0, STEP, 8'd200);
    ncu = 0;
    for (int i = 0; i < 20; i++) begin
      if (ctr_count_up) ncu++;
      if (ncu == 5) break;
      @(negedge clk);
    end
    chk("ab_reached5", ncu, 5);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("ab_cu_drop", int'(ctr_count_up), 0);
    chk("ab_busy_drop", int'(busy), 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bad += int'(cmd_done) + int'(ctr_count_up);
      @(negedge clk);
    end
    chk("ab_quiet", bad, 0);
    chk("ab_increments", int'(ctr_v), 5);
    // abort in IDLE neither blocks nor cancels acceptance
    abort = 1'b1;
    set_req(1, 1'b1, LOAD, 8'h77);
    #1 chk("ab_idle_ready", int'(req1_ready), 1);
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    set_req(1, 1'b0, LOAD, 8'h77);
    chk("ab_idle_load", int'(ctr_load), 1);
    chk("ab_idle_data", int'(ctr_data), 8'h77);
    @(negedge clk);
    chk("ab_idle_done", int'(cmd_done), 1);
    chk("ab_idle_src", int'(done_src), 1);
    chk("ab_idle_value", int'(ctr_v), 8'h77);
    // async reset in the middle of a STEP
    set_req(1, 1'b1, STEP, 8'd50);
    #1 chk("rs_ready", int'(req1_ready), 1);
    @(posedge clk); @(negedge clk);
    set_req(1, 1'b0, STEP, 8'd50);
    repeat (3) @(negedge clk);
    chk("rs_counting", int'(ctr_count_up), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_cu_async", int'(ctr_count_up), 0);
    chk("rs_busy_async", int'(busy), 0);
    chk("rs_no_done", int'(cmd_done), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      bad += int'(cmd_done) + int'(ctr_count_up);
      @(negedge clk);
    end
    chk("rs_quiet", bad, 0);
    set_req(0, 1'b1, LOAD, 8'h11);
    set_req(1, 1'b1, LOAD, 8'h22);
    #1;
    chk("rs_grant0_r0", int'(req0_ready), 1);
    chk("rs_grant0_r1", int'(req1_ready), 0);
    @(posedge clk); #1 set_req(0, 1'b0, LOAD, 8'h11);
    @(negedge clk);
    chk("rs_load_data", int'(ctr_data), 8'h11);
    @(negedge clk);
    chk("rs_done_src0", int'(done_src), 0);
    #1 chk("rs_grant1", int'(req1_ready), 1);
    @(posedge clk); #1 set_req(1, 1'b0, LOAD, 8'h22);
    @(negedge clk); @(negedge clk);
    chk("rs_done_src1", int'(done_src), 1);
    // random traffic against a transaction-level reference model
    preset(8'h00);
    ectr = 8'h00; lg = 1; free_at = 0; done_at = -1; win_lo = 1; win_hi = 0;
    is_load = 0; dsrc = 0; pend[0] = 0; pend[1] = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      in_win = cyc >= win_lo && cyc <= win_hi;
      chk("rnd_load", int'(ctr_load), int'(is_load && in_win));
      chk("rnd_count_up", int'(ctr_count_up), int'(!is_load && in_win));
      chk("rnd_busy", int'(busy), int'(in_win));
      chk("rnd_done", int'(cmd_done), int'(cyc == done_at));
      if (cyc == done_at) begin
        chk("rnd_done_src", int'(done_src), int'(dsrc));
        chk("rnd_value", int'(ctr_v), int'(ectr));
      end
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && cyc < 2400 && $urandom_range(0, 1) == 1) begin
          pend[r] = 1;
          pop[r] = 2'($urandom_range(0, 3));
          parg[r] = (pop[r] == STEP) ? 8'($urandom_range(0, 6)) :
                    (pop[r] == RUN) ? ctr_v + 8'($urandom_range(0, 8)) : 8'($urandom);
        end
        set_req(r[0], pend[r], pop[r], parg[r]);
      end
      #1;
      e0 = cyc >= free_at && pend[0] && (!pend[1] || lg);
      e1 = cyc >= free_at && pend[1] && (!pend[0] || !lg);
      chk("rnd_ready0", int'(req0_ready), int'(e0));
      chk("rnd_ready1", int'(req1_ready), int'(e1));
      if (e0 || e1) begin
        s = int'(e1);
        lg = e1; dsrc = e1; pend[s] = 0;
        n8 = (pop[s] == STEP) ? parg[s] : (pop[s] == RUN) ? parg[s] - ectr : 8'd0;
        is_load = pop[s] == LOAD;
        k = is_load ? 1 : int'(n8);
        ectr = is_load ? parg[s] : ectr + n8;
        win_lo = cyc + 1; win_hi = cyc + k;
        done_at = cyc + k + 1; free_at = cyc + k + 1;
      end
      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
